// File: rtl/wb_port_scheduler.sv
// Shares the GPR write port between pipeline writeback (A) and the long-latency unit (B),
// tracks pending B writes per GPR and stalls hazardous issue. Optional macro: WB_SCHED_BYPASS_EN.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef GPR_ENCODE_BITS
`define GPR_ENCODE_BITS 5
`endif

module wb_port_scheduler #(
  parameter int N            = `XLEN,
  parameter int REG_BITS     = `GPR_ENCODE_BITS,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                issue_valid,
  input  logic [REG_BITS-1:0] issue_rs1,
  input  logic [REG_BITS-1:0] issue_rs2,
  input  logic [REG_BITS-1:0] issue_rd,
  input  logic                issue_long,
  output logic                issue_stall,
  input  logic                a_valid,
  input  logic [REG_BITS-1:0] a_rd,
  input  logic [N-1:0]        a_data,
  output logic                a_ready,
  input  logic                b_valid,
  input  logic [REG_BITS-1:0] b_rd,
  input  logic [N-1:0]        b_data,
  output logic                b_ready,
  output logic                rf_we,
  output logic [REG_BITS-1:0] rf_addr,
  output logic [N-1:0]        rf_wd
);

  localparam int         NREGS = 1 << REG_BITS;
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [0:0] {PRIO_A = 1'b0, PRIO_B = 1'b1} state_t;

  state_t           state;
  logic [3:0]       starve_cnt;
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_next;
  logic [NREGS-1:0] busy_eff;
  logic             issue_accept;

  // Grant selection from the valids and current priority state
  always_comb begin
    a_ready = 1'b0;
    b_ready = 1'b0;
    case (state)
      PRIO_A: begin
        a_ready = a_valid;
        b_ready = b_valid & ~a_valid;
      end
      PRIO_B: begin
        b_ready = b_valid;
        a_ready = a_valid & ~b_valid;
      end
      default: begin
        a_ready = 1'b0;
        b_ready = 1'b0;
      end
    endcase
  end

  // Hazard check; with bypass, a register being written by B this cycle is treated as free
  always_comb begin
    busy_eff = busy;
`ifdef WB_SCHED_BYPASS_EN
    if (b_ready) begin
      busy_eff[b_rd] = 1'b0;
    end else begin
      busy_eff = busy;
    end
`endif
    if (issue_valid) begin
      issue_stall = busy_eff[issue_rs1] | busy_eff[issue_rs2] | busy_eff[issue_rd];
    end else begin
      issue_stall = 1'b0;
    end
  end

  assign issue_accept = issue_valid & ~issue_stall;

  // Scoreboard next state: set after clear so a same-index collision keeps the bit set
  always_comb begin
    busy_next = busy;
    if (b_ready) begin
      busy_next[b_rd] = 1'b0;
    end else begin
      busy_next = busy;
    end
    if (issue_accept & issue_long) begin
      busy_next[issue_rd] = 1'b1;
    end else begin
      busy_next[issue_rd] = busy_next[issue_rd];
    end
    busy_next[0] = 1'b0;
  end

  // Scoreboard register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= {NREGS{1'b0}};
    end else begin
      busy <= busy_next;
    end
  end

  // Arbiter FSM: B gets one forced-priority cycle after STARVE_LIMIT lost conflicts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= PRIO_A;
      starve_cnt <= 4'd0;
    end else begin
      case (state)
        PRIO_A: begin
          if (a_valid & b_valid) begin
            if (starve_cnt == LIMIT - 4'd1) begin
              state      <= PRIO_B;
              starve_cnt <= 4'd0;
            end else begin
              starve_cnt <= starve_cnt + 4'd1;
            end
          end else begin
            starve_cnt <= 4'd0;
          end
        end
        PRIO_B: begin
          state      <= PRIO_A;
          starve_cnt <= 4'd0;
        end
        default: begin
          state      <= PRIO_A;
          starve_cnt <= 4'd0;
        end
      endcase
    end
  end

  // Registered write port; x0 writes are granted but never enabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we   <= 1'b0;
      rf_addr <= {REG_BITS{1'b0}};
      rf_wd   <= {N{1'b0}};
    end else if (a_ready) begin
      rf_we   <= (a_rd != {REG_BITS{1'b0}});
      rf_addr <= a_rd;
      rf_wd   <= a_data;
    end else if (b_ready) begin
      rf_we   <= (b_rd != {REG_BITS{1'b0}});
      rf_addr <= b_rd;
      rf_wd   <= b_data;
    end else begin
      rf_we   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_port_scheduler.sv
// Self-checking bench for wb_port_scheduler: directed hazard/starvation/reset scenarios
// plus randomized traffic checked against a behavioural model.
module tb_wb_port_scheduler;
  localparam int N = 32, RB = 5, LIMIT = 4;
`ifdef WB_SCHED_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          issue_valid, issue_long, issue_stall;
  logic [RB-1:0] issue_rs1, issue_rs2, issue_rd;
  logic          a_valid, a_ready, b_valid, b_ready, rf_we;
  logic [RB-1:0] a_rd, b_rd, rf_addr;
  logic [N-1:0]  a_data, b_data, rf_wd;

  int n_tests = 0, n_fail = 0;

  // model state
  bit          mbusy [32];
  int          m_waits;
  bit          m_forced;
  bit          exp_we;
  logic [RB-1:0] exp_addr;
  logic [N-1:0]  exp_wd;
  logic [RB-1:0] bq[$];

  wb_port_scheduler #(.N(N), .REG_BITS(RB), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_rd(issue_rd), .issue_long(issue_long), .issue_stall(issue_stall),
    .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data), .b_ready(b_ready),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_wd(rf_wd)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    issue_valid = 1'b0; issue_long = 1'b0;
    issue_rs1 = '0; issue_rs2 = '0; issue_rd = '0;
    a_valid = 1'b0; a_rd = '0; a_data = '0;
    b_valid = 1'b0; b_rd = '0; b_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();
  endtask

  function automatic bit seen_busy(input logic [RB-1:0] r, input bit gb);
    return (r != 0) && mbusy[r] && !(BYP && gb && b_rd == r);
  endfunction

  // one cycle of the reference: check current outputs, then advance model state
  task automatic model_step(output bit ga, output bit gb, output bit st);
    check_eq("rnd_rf_we", rf_we, exp_we);
    if (exp_we) begin
      check_eq("rnd_rf_addr", rf_addr, exp_addr);
      check_eq("rnd_rf_wd", rf_wd, exp_wd);
    end
    if (m_forced) begin gb = b_valid; ga = a_valid && !b_valid; end
    else          begin ga = a_valid; gb = b_valid && !a_valid; end
    check_eq("rnd_a_ready", a_ready, ga);
    check_eq("rnd_b_ready", b_ready, gb);
    st = issue_valid && (seen_busy(issue_rs1, gb) || seen_busy(issue_rs2, gb) || seen_busy(issue_rd, gb));
    check_eq("rnd_stall", issue_stall, st);
    if (m_forced) begin
      m_forced = 1'b0; m_waits = 0;
    end else if (a_valid && b_valid) begin
      m_waits++;
      if (m_waits == LIMIT) begin m_forced = 1'b1; m_waits = 0; end
    end else m_waits = 0;
    exp_we = 1'b0;
    if (ga)      begin exp_we = (a_rd != 0); exp_addr = a_rd; exp_wd = a_data; end
    else if (gb) begin exp_we = (b_rd != 0); exp_addr = b_rd; exp_wd = b_data; end
    if (gb) mbusy[b_rd] = 1'b0;
    if (issue_valid && !st && issue_long && issue_rd != 0) mbusy[issue_rd] = 1'b1;
  endtask

  // long op to r, then a dependent (rs2 or WAW rd) instruction waits for B's write
  task automatic hazard(input string tag, input logic [RB-1:0] r, input bit waw);
    apply_reset();
    issue_valid = 1'b1; issue_long = 1'b1; issue_rd = r; issue_rs1 = '0; issue_rs2 = '0;
    @(negedge clk); check_eq({tag, "_long_issue"}, issue_stall, 1'b0);
    next_cycle();
    issue_long = 1'b0;
    issue_rd  = waw ? r : 5'd1;
    issue_rs2 = waw ? 5'd0 : r;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_eq({tag, "_held"}, issue_stall, 1'b1);
      check_eq({tag, "_no_early_we"}, rf_we, 1'b0);
      next_cycle();
    end
    b_valid = 1'b1; b_rd = r; b_data = 32'hCAFE_0000 | 32'(r);
    @(negedge clk);
    check_eq({tag, "_b_ready"}, b_ready, 1'b1);
    check_eq({tag, "_grant_cycle_stall"}, issue_stall, BYP ? 1'b0 : 1'b1);
    next_cycle();
    b_valid = 1'b0;
    @(negedge clk);
    check_eq({tag, "_release"}, issue_stall, 1'b0);
    check_eq({tag, "_rf_we"}, rf_we, 1'b1);
    check_eq({tag, "_rf_addr"}, rf_addr, r);
    check_eq({tag, "_rf_wd"}, rf_wd, 32'hCAFE_0000 | 32'(r));
    next_cycle();
    issue_valid = 1'b0;
  endtask

  initial begin
    bit ga, gb, st;
    int pat [6] = '{1, 1, 1, 1, 0, 1};
    logic [RB-1:0] want_addr;

    // reset state
    issue_valid = 1'b0; issue_long = 1'b0; issue_rs1 = '0; issue_rs2 = '0; issue_rd = '0;
    a_valid = 1'b0; a_rd = '0; a_data = '0; b_valid = 1'b0; b_rd = '0; b_data = '0;
    #3;
    check_eq("rst_rf_we", rf_we, 1'b0);
    check_eq("rst_rf_addr", rf_addr, 5'd0);
    check_eq("rst_rf_wd", rf_wd, 32'd0);
    check_eq("rst_ready", {a_ready, b_ready, issue_stall}, 3'b000);

    hazard("raw7", 5'd7, 1'b0);
    hazard("waw3", 5'd3, 1'b1);

    // B write to x0: granted, no write enable, no stall on x0
    apply_reset();
    b_valid = 1'b1; b_rd = 5'd0; b_data = 32'h1234_5678;
    issue_valid = 1'b1; issue_rs1 = 5'd0; issue_rs2 = 5'd0; issue_rd = 5'd0; issue_long = 1'b1;
    @(negedge clk);
    check_eq("x0_b_ready", b_ready, 1'b1);
    check_eq("x0_stall", issue_stall, 1'b0);
    next_cycle();
    b_valid = 1'b0; issue_long = 1'b0;
    @(negedge clk);
    check_eq("x0_rf_we", rf_we, 1'b0);
    check_eq("x0_stall_after", issue_stall, 1'b0);
    next_cycle();

    // starvation: both held high
    apply_reset();
    a_valid = 1'b1; a_rd = 5'd1; a_data = 32'hA000_0001;
    b_valid = 1'b1; b_rd = 5'd9; b_data = 32'h0B0B_0B0B;
    want_addr = '0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k > 0) check_eq("starve_rf_addr", rf_addr, want_addr);
      check_eq("starve_a_ready", a_ready, pat[k][0]);
      check_eq("starve_b_ready", b_ready, !pat[k][0]);
      want_addr = pat[k] ? a_rd : 5'd9;
      next_cycle();
      if (pat[k] != 0) begin a_rd = a_rd + 5'd1; a_data = a_data + 32'd1; end
    end
    @(negedge clk);
    check_eq("starve_rf_addr_last", rf_addr, want_addr);
    next_cycle();

    // randomized traffic against the model
    apply_reset();
    foreach (mbusy[i]) mbusy[i] = 1'b0;
    m_waits = 0; m_forced = 1'b0; exp_we = 1'b0; exp_addr = '0; exp_wd = '0;
    bq.delete();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      model_step(ga, gb, st);
      if (gb) void'(bq.pop_front());
      if (issue_valid && !st && issue_long) bq.push_back(issue_rd);
      next_cycle();
      if (!a_valid || ga) begin
        a_valid = ($urandom_range(0, 2) != 0);
        a_rd = 5'($urandom_range(0, 7));
        a_data = $urandom;
      end
      if (!b_valid || gb) begin
        if (bq.size() > 0 && $urandom_range(0, 1) == 1) begin
          b_valid = 1'b1; b_rd = bq[0]; b_data = $urandom;
        end else b_valid = 1'b0;
      end
      if (!issue_valid || !st) begin
        issue_valid = ($urandom_range(0, 1) == 1);
        issue_rs1 = 5'($urandom_range(0, 7));
        issue_rs2 = 5'($urandom_range(0, 7));
        issue_rd  = 5'($urandom_range(0, 7));
        issue_long = ($urandom_range(0, 2) == 0);
      end
    end

    // reset mid-stream with busy[5] set and the arbiter in PRIO_B
    apply_reset();
    issue_valid = 1'b1; issue_long = 1'b1; issue_rd = 5'd5;
    next_cycle();
    issue_valid = 1'b0; issue_long = 1'b0; issue_rd = '0;
    a_valid = 1'b1; a_rd = 5'd2; a_data = 32'h2222_2222;
    b_valid = 1'b1; b_rd = 5'd9; b_data = 32'h9999_9999;
    repeat (4) next_cycle();
    @(negedge clk);
    check_eq("midrst_prio_b", {a_ready, b_ready}, 2'b01);
    #1;
    rst_n = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
    #1;
    check_eq("midrst_rf", {rf_we, rf_addr, rf_wd}, 38'd0);
    check_eq("midrst_ready", {a_ready, b_ready, issue_stall}, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();
    issue_valid = 1'b1; issue_rs1 = 5'd5; issue_rs2 = '0; issue_rd = 5'd1;
    a_valid = 1'b1; b_valid = 1'b1;
    @(negedge clk);
    check_eq("midrst_busy_cleared", issue_stall, 1'b0);
    check_eq("midrst_prio_a", {a_ready, b_ready}, 2'b10);
    next_cycle();
    issue_valid = 1'b0; a_valid = 1'b0; b_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
